dat_phys: RTL and testbench

- Physical-layer end of the SD DAT handshake: accepts a transfer request from the host-side DAT controller (strobe, direction, block count, multiple flag) and returns serial_ready, complete and ack_out.
- Serializes TX-FIFO words onto a single DAT line (write) or deserializes DAT into the RX FIFO (read), one bit per clock.
- Appends and checks CRC16, sits between the FIFO controller and the card DAT pad.

---
 rtl/dat_phys.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_dat_phys.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dat_phys.sv
// dat_phys: single-line SD DAT physical engine.
// Serialises TX FIFO words onto DAT (write) or deserialises DAT into the RX
// FIFO (read), appending or checking CRC16-CCITT per block. It also handles
// the write CRC-status token and busy phase, and runs the
// strobe/complete/ack handshake with the host-side DAT controller.
module dat_phys #(
    parameter int BLOCK_WORDS = 128,
    parameter int TIMEOUT     = 4096,
    parameter int STATUS_GAP  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        strobe_in,
    input  logic        ack_in,
    input  logic [3:0]  blocks,
    input  logic        writeRead,
    input  logic        multiple,
    output logic        serial_ready,
    output logic        complete,
    output logic        ack_out,
    input  logic [31:0] dataFromFifo,
    input  logic        tx_empty,
    output logic        readFifo,
    output logic [31:0] dataToFifo,
    output logic        writeFifo,
    input  logic        rx_full,
    input  logic        dat_in,
    output logic        dat_out,
    output logic        dat_oe,
    output logic        crc_error,
    output logic        timeout_error,
    output logic        fifo_error
);

    typedef enum logic [3:0] {
        S_IDLE, S_W_START, S_W_DATA, S_W_CRC, S_W_END, S_W_GAP, S_W_STATUS,
        S_W_BUSY, S_R_WAIT, S_R_DATA, S_R_CRC, S_R_END, S_DONE, S_ACK
    } state_t;

    state_t      r_state;
    logic [31:0] r_shift;      // data shift register (TX and RX)
    logic [15:0] r_crc;        // running CRC over data bits of the current block
    logic [15:0] r_rxcrc;      // CRC received from the card
    logic [4:0]  r_bit;        // bit position within the current word
    logic [15:0] r_word;       // word index within the block
    logic [3:0]  r_cnt;        // CRC / status bit counter
    logic [2:0]  r_stat;       // status token bits
    logic        r_sync;       // status start bit seen
    logic [3:0]  r_nblk;       // blocks remaining, including the current one
    logic [31:0] r_tmo;        // timeout / gap down-counter

    logic [31:0] w_tx_word;
    logic [31:0] w_rx_word;
    logic        w_last_word;
    logic [3:0]  w_nblk;
    logic        w_no_err;
    logic        w_rx_bad;

    // Serial CRC16-CCITT step, MSB first, polynomial 0x1021
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    // An empty TX FIFO yields an all-ones word (line stays high) instead of stale data
    assign w_tx_word   = tx_empty ? 32'hFFFF_FFFF : dataFromFifo;
    assign w_rx_word   = {r_shift[30:0], dat_in};
    assign w_last_word = (r_word == 16'(BLOCK_WORDS - 1));
    assign w_nblk      = multiple ? ((blocks == 4'd0) ? 4'd1 : blocks) : 4'd1;
    assign w_no_err    = !crc_error && !timeout_error && !fifo_error;
    assign w_rx_bad    = (r_rxcrc != r_crc) || !dat_in;

    // Transfer state machine; every output is a register set on the edge entering its state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            serial_ready  <= 1'b1;
            complete      <= 1'b0;
            ack_out       <= 1'b0;
            readFifo      <= 1'b0;
            writeFifo     <= 1'b0;
            dataToFifo    <= 32'h0;
            dat_out       <= 1'b1;
            dat_oe        <= 1'b0;
            crc_error     <= 1'b0;
            timeout_error <= 1'b0;
            fifo_error    <= 1'b0;
            r_shift       <= 32'h0;
            r_crc         <= 16'h0;
            r_rxcrc       <= 16'h0;
            r_bit         <= 5'd0;
            r_word        <= 16'd0;
            r_cnt         <= 4'd0;
            r_stat        <= 3'd0;
            r_sync        <= 1'b0;
            r_nblk        <= 4'd0;
            r_tmo         <= 32'd0;
        end else begin
            readFifo  <= 1'b0;
            writeFifo <= 1'b0;
            ack_out   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (strobe_in) begin
                        r_nblk        <= w_nblk;
                        crc_error     <= 1'b0;
                        timeout_error <= 1'b0;
                        fifo_error    <= 1'b0;
                        serial_ready  <= 1'b0;
                        if (writeRead) begin
                            // start bit goes out while the first word is popped
                            r_state  <= S_W_START;
                            dat_oe   <= 1'b1;
                            dat_out  <= 1'b0;
                            r_crc    <= 16'h0;
                            r_shift  <= w_tx_word;
                            readFifo <= !tx_empty;
                            if (tx_empty) fifo_error <= 1'b1;
                        end else begin
                            r_state <= S_R_WAIT;
                            r_tmo   <= 32'(TIMEOUT - 1);
                        end
                    end
                end
                S_W_START: begin
                    dat_out <= r_shift[31];
                    r_shift <= {r_shift[30:0], 1'b0};
                    r_crc   <= crc_step(r_crc, r_shift[31]);
                    r_bit   <= 5'd31;
                    r_word  <= 16'd0;
                    r_state <= S_W_DATA;
                end
                S_W_DATA: begin
                    if (r_bit == 5'd0) begin
                        if (w_last_word) begin
                            r_state <= S_W_CRC;
                            dat_out <= r_crc[15];
                            r_cnt   <= 4'd15;
                        end else begin
                            dat_out <= r_shift[31];
                            r_shift <= {r_shift[30:0], 1'b0};
                            r_crc   <= crc_step(r_crc, r_shift[31]);
                            r_bit   <= 5'd31;
                            r_word  <= r_word + 16'd1;
                        end
                    end else begin
                        dat_out <= r_shift[31];
                        r_crc   <= crc_step(r_crc, r_shift[31]);
                        r_bit   <= r_bit - 5'd1;
                        // bit 0 of a non-final word: fetch the next word alongside it
                        if (r_bit == 5'd1 && !w_last_word) begin
                            r_shift  <= w_tx_word;
                            readFifo <= !tx_empty;
                            if (tx_empty) fifo_error <= 1'b1;
                        end else begin
                            r_shift <= {r_shift[30:0], 1'b0};
                        end
                    end
                end
                S_W_CRC: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_W_END;
                        dat_out <= 1'b1;
                    end else begin
                        dat_out <= r_crc[r_cnt - 4'd1];
                        r_cnt   <= r_cnt - 4'd1;
                    end
                end
                S_W_END: begin
                    dat_oe  <= 1'b0;
                    dat_out <= 1'b1;
                    r_sync  <= 1'b0;
                    if (STATUS_GAP == 0) begin
                        r_state <= S_W_STATUS;
                        r_tmo   <= 32'(TIMEOUT - 1);
                    end else begin
                        r_state <= S_W_GAP;
                        r_tmo   <= 32'(STATUS_GAP - 1);
                    end
                end
                S_W_GAP: begin
                    if (r_tmo == 32'd0) begin
                        r_state <= S_W_STATUS;
                        r_tmo   <= 32'(TIMEOUT - 1);
                    end else begin
                        r_tmo <= r_tmo - 32'd1;
                    end
                end
                S_W_STATUS: begin
                    if (!r_sync) begin
                        if (!dat_in) begin
                            r_sync <= 1'b1;
                            r_cnt  <= 4'd0;
                        end else if (r_tmo == 32'd0) begin
                            timeout_error <= 1'b1;
                            complete      <= 1'b1;
                            r_state       <= S_DONE;
                        end else begin
                            r_tmo <= r_tmo - 32'd1;
                        end
                    end else begin
                        r_stat <= {r_stat[1:0], dat_in};
                        r_cnt  <= r_cnt + 4'd1;
                        if (r_cnt == 4'd3) begin
                            // three status bits then the end bit: only "010",1 is accepted
                            if ({r_stat, dat_in} == 4'b0101) begin
                                r_state <= S_W_BUSY;
                                r_tmo   <= 32'(TIMEOUT - 1);
                            end else begin
                                crc_error <= 1'b1;
                                complete  <= 1'b1;
                                r_state   <= S_DONE;
                            end
                        end
                    end
                end
                S_W_BUSY: begin
                    if (dat_in) begin
                        r_nblk <= r_nblk - 4'd1;
                        if (r_nblk > 4'd1 && w_no_err) begin
                            r_state  <= S_W_START;
                            dat_oe   <= 1'b1;
                            dat_out  <= 1'b0;
                            r_crc    <= 16'h0;
                            r_shift  <= w_tx_word;
                            readFifo <= !tx_empty;
                            if (tx_empty) fifo_error <= 1'b1;
                        end else begin
                            complete <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end else if (r_tmo == 32'd0) begin
                        timeout_error <= 1'b1;
                        complete      <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo - 32'd1;
                    end
                end
                S_R_WAIT: begin
                    if (!dat_in) begin
                        r_state <= S_R_DATA;
                        r_crc   <= 16'h0;
                        r_bit   <= 5'd0;
                        r_word  <= 16'd0;
                    end else if (r_tmo == 32'd0) begin
                        timeout_error <= 1'b1;
                        complete      <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo - 32'd1;
                    end
                end
                S_R_DATA: begin
                    r_shift <= w_rx_word;
                    r_crc   <= crc_step(r_crc, dat_in);
                    r_bit   <= r_bit + 5'd1;
                    if (r_bit == 5'd31) begin
                        // a full word is pushed next cycle, or dropped if the RX FIFO is full
                        if (rx_full) begin
                            fifo_error <= 1'b1;
                        end else begin
                            dataToFifo <= w_rx_word;
                            writeFifo  <= 1'b1;
                        end
                        r_word <= r_word + 16'd1;
                        if (w_last_word) begin
                            r_state <= S_R_CRC;
                            r_cnt   <= 4'd0;
                        end
                    end
                end
                S_R_CRC: begin
                    r_rxcrc <= {r_rxcrc[14:0], dat_in};
                    r_cnt   <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) r_state <= S_R_END;
                end
                S_R_END: begin
                    if (w_rx_bad) crc_error <= 1'b1;
                    r_nblk <= r_nblk - 4'd1;
                    if (!w_rx_bad && r_nblk > 4'd1 && !fifo_error && !timeout_error) begin
                        r_state <= S_R_WAIT;
                        r_tmo   <= 32'(TIMEOUT - 1);
                    end else begin
                        complete <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    dat_oe <= 1'b0;
                    if (ack_in) begin
                        complete <= 1'b0;
                        ack_out  <= 1'b1;
                        r_state  <= S_ACK;
                    end
                end
                S_ACK: begin
                    serial_ready <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state      <= S_IDLE;
                    serial_ready <= 1'b1;
                    dat_oe       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dat_phys.sv
// tb_dat_phys: directed-vector bench for dat_phys (BLOCK_WORDS=2, TIMEOUT=16).
// Models the TX FIFO and the card side of the DAT line; expected CRCs come
// from a polynomial long-division model.
module tb_dat_phys;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        strobe_in = 1'b0;
    logic        ack_in = 1'b0;
    logic [3:0]  blocks = 4'd0;
    logic        writeRead = 1'b0;
    logic        multiple = 1'b0;
    logic        serial_ready, complete, ack_out;
    logic [31:0] dataFromFifo;
    logic        tx_empty;
    logic        readFifo;
    logic [31:0] dataToFifo;
    logic        writeFifo;
    logic        rx_full = 1'b0;
    logic        dat_in = 1'b1;
    logic        dat_out, dat_oe;
    logic        crc_error, timeout_error, fifo_error;

    int n_vec = 0;
    int n_mis = 0;

    dat_phys #(.BLOCK_WORDS(2), .TIMEOUT(16), .STATUS_GAP(2)) dut (
        .clock(clock), .reset(reset), .strobe_in(strobe_in), .ack_in(ack_in),
        .blocks(blocks), .writeRead(writeRead), .multiple(multiple),
        .serial_ready(serial_ready), .complete(complete), .ack_out(ack_out),
        .dataFromFifo(dataFromFifo), .tx_empty(tx_empty), .readFifo(readFifo),
        .dataToFifo(dataToFifo), .writeFifo(writeFifo), .rx_full(rx_full),
        .dat_in(dat_in), .dat_out(dat_out), .dat_oe(dat_oe),
        .crc_error(crc_error), .timeout_error(timeout_error), .fifo_error(fifo_error)
    );

    always #5 clock = ~clock;

    // TX FIFO model: first-word-fall-through, popped on readFifo
    logic [31:0] tx_mem [0:7];
    int tx_rd = 0;
    int tx_wr = 0;
    assign tx_empty     = (tx_rd == tx_wr);
    assign dataFromFifo = tx_mem[tx_rd % 8];
    always @(posedge clock) if (readFifo && tx_rd != tx_wr) tx_rd <= tx_rd + 1;

    // Line / pulse monitor, sampled on the falling edge
    logic        bit_log [0:1023];
    logic [31:0] rxw_log [0:31];
    int n_bits = 0;
    int n_rd   = 0;
    int n_wr   = 0;
    int n_ack  = 0;
    always @(negedge clock) begin
        if (dat_oe && n_bits < 1024) begin
            bit_log[n_bits] <= dat_out;
            n_bits <= n_bits + 1;
        end
        if (readFifo) n_rd <= n_rd + 1;
        if (writeFifo && n_wr < 32) begin
            rxw_log[n_wr] <= dataToFifo;
            n_wr <= n_wr + 1;
        end
        if (ack_out) n_ack <= n_ack + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // CRC16-CCITT, init 0, as remainder of M(x)*x^16 divided by 0x11021
    function automatic logic [15:0] crc_model(input logic [31:0] a, input logic [31:0] b);
        logic [79:0] r;
        r = {a, b, 16'h0000};
        for (int i = 79; i >= 16; i--)
            if (r[i]) r[i -: 17] = r[i -: 17] ^ 17'h1_1021;
        return r[15:0];
    endfunction

    task automatic push_tx(input logic [31:0] w);
        tx_mem[tx_wr % 8] = w;
        tx_wr++;
    endtask

    task automatic start_xfer(input logic wr, input logic mul, input logic [3:0] nb);
        writeRead = wr;
        multiple  = mul;
        blocks    = nb;
        strobe_in = 1'b1;
        tick();
        strobe_in = 1'b0;
    endtask

    task automatic wait_oe_low(input string tag);
        for (int i = 0; i < 300 && dat_oe; i++) tick();
        chk(tag, 32'(dat_oe), 32'd0);
    endtask

    task automatic wait_complete(input string tag, input int limit);
        for (int i = 0; i < limit && !complete; i++) tick();
        chk(tag, 32'(complete), 32'd1);
    endtask

    // Card response after a written block: start, 3 status bits, end, 5 busy cycles
    task automatic card_status(input logic [2:0] st);
        dat_in = 1'b1;
        tick(); tick(); tick();
        dat_in = 1'b0;
        tick();
        for (int i = 2; i >= 0; i--) begin
            dat_in = st[i];
            tick();
        end
        dat_in = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            dat_in = 1'b0;
            tick();
        end
        dat_in = 1'b1;
    endtask

    // Card sends one read block: idle, start, 64 data bits, CRC (optionally corrupted), end
    task automatic send_block(input logic [31:0] w0, input logic [31:0] w1, input logic flip);
        logic [63:0] msg;
        logic [15:0] c;
        msg = {w0, w1};
        c = crc_model(w0, w1) ^ (flip ? 16'h0100 : 16'h0000);
        dat_in = 1'b1; tick(); tick();
        dat_in = 1'b0; tick();
        for (int i = 63; i >= 0; i--) begin dat_in = msg[i]; tick(); end
        for (int i = 15; i >= 0; i--) begin dat_in = c[i];   tick(); end
        dat_in = 1'b1; tick();
    endtask

    // Checks one written block framing: start, two words, CRC, end bit
    task automatic check_wbits(input string tag, input int base, input logic [31:0] w0,
                               input logic [31:0] w1);
        logic [31:0] g0, g1;
        logic [15:0] gc;
        chk({tag, "_len"}, 32'(n_bits - base), 32'd82);
        if (base + 82 <= 1024) begin
            g0 = '0; g1 = '0; gc = '0;
            for (int i = 0; i < 32; i++) g0 = {g0[30:0], bit_log[base + 1 + i]};
            for (int i = 0; i < 32; i++) g1 = {g1[30:0], bit_log[base + 33 + i]};
            for (int i = 0; i < 16; i++) gc = {gc[14:0], bit_log[base + 65 + i]};
            chk({tag, "_start"}, 32'(bit_log[base]), 32'd0);
            chk({tag, "_w0"}, g0, w0);
            chk({tag, "_w1"}, g1, w1);
            chk({tag, "_crc"}, 32'(gc), 32'(crc_model(w0, w1)));
            chk({tag, "_end"}, 32'(bit_log[base + 81]), 32'd1);
        end
    endtask

    task automatic finish_ack(input string tag);
        int a0;
        a0 = n_ack;
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        chk({tag, "_ack"}, 32'(ack_out), 32'd1);
        chk({tag, "_cmp_clr"}, 32'(complete), 32'd0);
        tick();
        chk({tag, "_ack_1cyc"}, 32'(ack_out), 32'd0);
        chk({tag, "_idle"}, 32'(serial_ready), 32'd1);
        chk({tag, "_ack_cnt"}, 32'(n_ack - a0), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bb, rb, wb, hit;
        logic [31:0] rw [0:5];
        rw[0] = 32'h0123_4567; rw[1] = 32'h89AB_CDEF; rw[2] = 32'hFFFF_0000;
        rw[3] = 32'h0000_FFFF; rw[4] = 32'hC3C3_3C3C; rw[5] = 32'h8000_0001;

        // Reset state
        tick(); tick();
        chk("rst_ready", 32'(serial_ready), 32'd1);
        chk("rst_dat_out", 32'(dat_out), 32'd1);
        chk("rst_dat_oe", 32'(dat_oe), 32'd0);
        chk("rst_complete", 32'(complete), 32'd0);
        chk("rst_ack", 32'(ack_out), 32'd0);
        chk("rst_rd", 32'(readFifo), 32'd0);
        chk("rst_wr", 32'(writeFifo), 32'd0);
        chk("rst_data", dataToFifo, 32'd0);
        chk("rst_errs", {29'd0, crc_error, timeout_error, fifo_error}, 32'd0);
        reset = 1'b0;
        tick();

        // Single-block write with good status and busy
        push_tx(32'hA5A5_0F0F); push_tx(32'h1234_5678);
        bb = n_bits; rb = n_rd;
        start_xfer(1'b1, 1'b0, 4'd0);
        chk("wr1_start_oe", 32'(dat_oe), 32'd1);
        chk("wr1_start_bit", 32'(dat_out), 32'd0);
        chk("wr1_not_ready", 32'(serial_ready), 32'd0);
        wait_oe_low("wr1_release");
        check_wbits("wr1", bb, 32'hA5A5_0F0F, 32'h1234_5678);
        chk("wr1_pops", 32'(n_rd - rb), 32'd2);
        card_status(3'b010);
        wait_complete("wr1_complete", 40);
        chk("wr1_errs", {29'd0, crc_error, timeout_error, fifo_error}, 32'd0);
        finish_ack("wr1");

        // Three-block read with correct CRCs
        wb = n_wr;
        start_xfer(1'b0, 1'b1, 4'd3);
        for (int b = 0; b < 3; b++) send_block(rw[2*b], rw[2*b+1], 1'b0);
        wait_complete("rd3_complete", 10);
        chk("rd3_pushes", 32'(n_wr - wb), 32'd6);
        for (int i = 0; i < 6; i++)
            if (wb + i < 32) chk($sformatf("rd3_word%0d", i), rxw_log[wb + i], rw[i]);
        chk("rd3_crc_err", 32'(crc_error), 32'd0);
        finish_ack("rd3");

        // Read, first of three blocks with a flipped CRC bit
        wb = n_wr;
        start_xfer(1'b0, 1'b1, 4'd3);
        send_block(rw[4], rw[5], 1'b1);
        wait_complete("rdbad_complete", 3);
        chk("rdbad_crc_err", 32'(crc_error), 32'd1);
        chk("rdbad_to_err", 32'(timeout_error), 32'd0);
        tick(); tick();
        chk("rdbad_pushes", 32'(n_wr - wb), 32'd2);
        finish_ack("rdbad");

        // Read timeout with DAT idle high
        dat_in = 1'b1;
        start_xfer(1'b0, 1'b0, 4'd0);
        hit = 0;
        for (int k = 1; k <= 40; k++) begin
            if (complete && hit == 0) hit = k;
            if (hit == 0) tick();
        end
        chk("to_cycle", 32'(hit), 32'd17);
        chk("to_err", 32'(timeout_error), 32'd1);
        chk("to_crc_err", 32'(crc_error), 32'd0);
        finish_ack("to");

        // Two-block write rejected by status "101"
        push_tx(32'h0F1E_2D3C); push_tx(32'h4B5A_6978);
        bb = n_bits; rb = n_rd;
        start_xfer(1'b1, 1'b1, 4'd2);
        wait_oe_low("wrrej_release");
        card_status(3'b101);
        wait_complete("wrrej_complete", 40);
        tick(); tick(); tick();
        chk("wrrej_crc_err", 32'(crc_error), 32'd1);
        chk("wrrej_pops", 32'(n_rd - rb), 32'd2);
        check_wbits("wrrej", bb, 32'h0F1E_2D3C, 32'h4B5A_6978);
        finish_ack("wrrej");

        // TX underflow on the second word
        push_tx(32'hDEAD_BEEF);
        bb = n_bits; rb = n_rd;
        start_xfer(1'b1, 1'b0, 4'd0);
        wait_oe_low("uf_release");
        check_wbits("uf", bb, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        chk("uf_pops", 32'(n_rd - rb), 32'd1);
        chk("uf_fifo_err", 32'(fifo_error), 32'd1);
        card_status(3'b010);
        wait_complete("uf_complete", 40);
        chk("uf_crc_err", 32'(crc_error), 32'd0);
        finish_ack("uf");

        // Asynchronous reset in the middle of write data
        push_tx(32'h5555_AAAA); push_tx(32'h3333_CCCC);
        start_xfer(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("mid_oe_before", 32'(dat_oe), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_oe", 32'(dat_oe), 32'd0);
        chk("mid_rst_ready", 32'(serial_ready), 32'd1);
        chk("mid_rst_complete", 32'(complete), 32'd0);
        chk("mid_rst_errs", {29'd0, crc_error, timeout_error, fifo_error}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
